// File: rtl/brick_memory.sv
`default_nettype none
// ============================================================================
// Module      : brick_memory
// Description : Brick-field health store with probe port, health write-back,
//               bricks-left counter and a 4-entry redraw FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module brick_memory #(
  parameter int         BRICKX      = 20,
  parameter int         BRICKY      = 10,
  parameter int         COLS        = 16,
  parameter int         ROWS        = 8,
  parameter logic [1:0] INIT_HEALTH = 2'd3
) (
  input  logic       clk,
  input  logic       reset,
  output logic       ready,
  input  logic       query_valid,
  input  logic [9:0] memx,
  input  logic [9:0] memy,
  output logic       resp_valid,
  output logic [9:0] brickx,
  output logic [9:0] bricky,
  output logic [1:0] health,
  input  logic       game_write,
  input  logic [9:0] wr_x,
  input  logic [9:0] wr_y,
  input  logic [1:0] game_health,
  output logic       draw_valid,
  input  logic       draw_ready,
  output logic [9:0] draw_x,
  output logic [9:0] draw_y,
  output logic [1:0] draw_health,
  output logic [7:0] bricks_left,
  output logic       all_cleared,
  output logic       overflow
);

  localparam int c_nbrick = COLS * ROWS;
  localparam int c_iw     = $clog2(c_nbrick);

  typedef enum logic [0:0] {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [c_iw-1:0]   idx_q, idx_d;
  logic              ready_q, ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [9:0]        brickx_q, brickx_d, bricky_q, bricky_d;
  logic [1:0]        health_q, health_d;
  logic [7:0]        bricks_left_q, bricks_left_d;
  logic              overflow_q, overflow_d;
  logic [1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0]        count_q, count_d;

  logic [1:0]        mem_q [c_nbrick];
  logic [21:0]       fifo_q [4];

  logic              mem_we;
  logic [c_iw-1:0]   mem_waddr;
  logic [1:0]        mem_wdata;
  logic              push, push_ok, pop;
  logic [21:0]       push_data;

  // Probe and write-back address decode
  logic [9:0]        q_col, q_row, w_col, w_row;
  logic              q_in, w_in;
  logic [c_iw-1:0]   q_idx, w_idx;
  logic [9:0]        q_cx, q_cy, w_cx, w_cy;
  logic [1:0]        w_stored;

  always_comb begin
    q_col = memx / 10'(BRICKX);
    q_row = memy / 10'(BRICKY);
    w_col = wr_x / 10'(BRICKX);
    w_row = wr_y / 10'(BRICKY);
    q_in  = (memx < 10'(COLS * BRICKX)) && (memy < 10'(ROWS * BRICKY));
    w_in  = (wr_x < 10'(COLS * BRICKX)) && (wr_y < 10'(ROWS * BRICKY));
    q_idx = c_iw'(q_row * 10'(COLS) + q_col);
    w_idx = c_iw'(w_row * 10'(COLS) + w_col);
    q_cx  = 10'(q_col * 10'(BRICKX));
    q_cy  = 10'(q_row * 10'(BRICKY));
    w_cx  = 10'(w_col * 10'(BRICKX));
    w_cy  = 10'(w_row * 10'(BRICKY));
    w_stored = mem_q[w_idx];
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ready_d       = ready_q;
    brickx_d      = brickx_q;
    bricky_d      = bricky_q;
    health_d      = health_q;
    bricks_left_d = bricks_left_q;
    overflow_d    = overflow_q;
    mem_we        = 1'b0;
    mem_waddr     = idx_q;
    mem_wdata     = INIT_HEALTH;
    push          = 1'b0;
    push_data     = {w_cx, w_cy, game_health};
    resp_valid_d  = query_valid && (state_q == S_RUN);

    case (state_q)
      S_INIT: begin
        mem_we = 1'b1;
        if (idx_q == c_iw'(c_nbrick - 1)) begin
          state_d       = S_RUN;
          ready_d       = 1'b1;
          bricks_left_d = 8'(c_nbrick);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_RUN: begin
        if (query_valid) begin
          brickx_d = q_in ? q_cx : 10'd0;
          bricky_d = q_in ? q_cy : 10'd0;
          health_d = q_in ? mem_q[q_idx] : 2'd0;
        end
        // Dead bricks stay dead, so the count can only fall from nonzero health
        if (game_write && w_in && (w_stored != 2'd0) && (game_health != w_stored)) begin
          mem_we    = 1'b1;
          mem_waddr = w_idx;
          mem_wdata = game_health;
          push      = 1'b1;
          if (game_health == 2'd0) bricks_left_d = bricks_left_q - 8'd1;
        end
      end
      default: state_d = S_INIT;
    endcase

    pop     = (count_q != 3'd0) && draw_ready;
    push_ok = push && ((count_q != 3'd4) || pop);
    if (push && !push_ok) overflow_d = 1'b1;
    count_d  = count_q + {2'b00, push_ok} - {2'b00, pop};
    rd_ptr_d = rd_ptr_q + {1'b0, pop};
    wr_ptr_d = wr_ptr_q + {1'b0, push_ok};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_INIT;
      idx_q         <= '0;
      ready_q       <= 1'b0;
      resp_valid_q  <= 1'b0;
      brickx_q      <= '0;
      bricky_q      <= '0;
      health_q      <= '0;
      bricks_left_q <= '0;
      overflow_q    <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      ready_q       <= ready_d;
      resp_valid_q  <= resp_valid_d;
      brickx_q      <= brickx_d;
      bricky_q      <= bricky_d;
      health_q      <= health_d;
      bricks_left_q <= bricks_left_d;
      overflow_q    <= overflow_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage arrays need no reset: init rewrites the field, FIFO output is gated
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem_q[mem_waddr] <= mem_wdata;
    if (!reset && push_ok) fifo_q[wr_ptr_q] <= push_data;
  end

  assign ready       = ready_q;
  assign resp_valid  = resp_valid_q;
  assign brickx      = brickx_q;
  assign bricky      = bricky_q;
  assign health      = health_q;
  assign bricks_left = bricks_left_q;
  assign overflow    = overflow_q;
  assign all_cleared = ready_q && (bricks_left_q == 8'd0);
  assign draw_valid  = (count_q != 3'd0);
  assign draw_x      = draw_valid ? fifo_q[rd_ptr_q][21:12] : 10'd0;
  assign draw_y      = draw_valid ? fifo_q[rd_ptr_q][11:2]  : 10'd0;
  assign draw_health = draw_valid ? fifo_q[rd_ptr_q][1:0]   : 2'd0;

endmodule
`default_nettype wire

// File: tb/tb_brick_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_brick_memory
// Description : Scoreboard bench for brick_memory (probe and redraw queues).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_brick_memory;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] h;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ready, query_valid, resp_valid, game_write, draw_valid, draw_ready;
  logic [9:0] memx, memy, brickx, bricky, wr_x, wr_y, draw_x, draw_y;
  logic [1:0] health, game_health, draw_health;
  logic [7:0] bricks_left;
  logic       all_cleared, overflow;

  int   checks = 0;
  int   errors = 0;
  ent_t q_resp[$];
  ent_t q_draw[$];
  logic [1:0] exp_h [128];
  int   exp_left;
  logic exp_ovf;

  brick_memory dut (
    .clk(clk), .reset(reset), .ready(ready),
    .query_valid(query_valid), .memx(memx), .memy(memy),
    .resp_valid(resp_valid), .brickx(brickx), .bricky(bricky), .health(health),
    .game_write(game_write), .wr_x(wr_x), .wr_y(wr_y), .game_health(game_health),
    .draw_valid(draw_valid), .draw_ready(draw_ready),
    .draw_x(draw_x), .draw_y(draw_y), .draw_health(draw_health),
    .bricks_left(bricks_left), .all_cleared(all_cleared), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Scoreboard: responses and accepted redraw entries compared mid-cycle
  always @(negedge clk) begin
    if (resp_valid) begin
      checks++;
      if (q_resp.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got %0d,%0d,%0d with nothing expected", brickx, bricky, health);
      end else begin
        ent_t e;
        e = q_resp.pop_front();
        if ({brickx, bricky, health} !== e)
          begin errors++; $display("FAIL resp: got %0d,%0d,%0d want %0d,%0d,%0d", brickx, bricky, health, e.x, e.y, e.h); end
      end
    end
    if (draw_valid && draw_ready) begin
      checks++;
      if (q_draw.size() == 0) begin
        errors++;
        $display("FAIL draw_unexpected: got %0d,%0d,%0d with nothing expected", draw_x, draw_y, draw_health);
      end else begin
        ent_t e;
        e = q_draw.pop_front();
        if ({draw_x, draw_y, draw_health} !== e)
          begin errors++; $display("FAIL draw: got %0d,%0d,%0d want %0d,%0d,%0d", draw_x, draw_y, draw_health, e.x, e.y, e.h); end
      end
    end
  end

  function automatic int fidx(int x, int y);
    if (x >= 320 || y >= 80) return -1;
    return (y / 10) * 16 + (x / 20);
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    query_valid = 1'b0;
    game_write  = 1'b0;
  endtask

  task automatic model_init();
    for (int i = 0; i < 128; i++) exp_h[i] = 2'd3;
    exp_left = 128;
    exp_ovf  = 1'b0;
  endtask

  task automatic drive_query(int x, int y);
    int i;
    ent_t e;
    i = fidx(x, y);
    query_valid = 1'b1; memx = 10'(x); memy = 10'(y);
    if (i < 0) e = '0;
    else e = '{x: 10'((x / 20) * 20), y: 10'((y / 10) * 10), h: exp_h[i]};
    q_resp.push_back(e);
  endtask

  task automatic drive_write(int x, int y, logic [1:0] g);
    int i;
    i = fidx(x, y);
    game_write = 1'b1; wr_x = 10'(x); wr_y = 10'(y); game_health = g;
    if (i >= 0 && exp_h[i] != 2'd0 && exp_h[i] != g) begin
      exp_h[i] = g;
      if (q_draw.size() < 4) q_draw.push_back('{x: 10'((x / 20) * 20), y: 10'((y / 10) * 10), h: g});
      else exp_ovf = 1'b1;
      if (g == 2'd0) exp_left--;
    end
  endtask

  task automatic wait_ready(string name);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (!ready && cnt < 400) begin cnt++; @(negedge clk); end
    checks++;
    if (cnt !== 128) begin errors++; $display("FAIL %s_init_cycles: got %0d want 128", name, cnt); end
    checks++;
    if (bricks_left !== 8'd128) begin errors++; $display("FAIL %s_bricks_left: got %0d want 128", name, bricks_left); end
    step();
  endtask

  task automatic drain(string name);
    int cnt;
    cnt = 0;
    while ((q_draw.size() != 0 || q_resp.size() != 0) && cnt < 50) begin step(); cnt++; end
    step();
    checks++;
    if (q_draw.size() != 0 || q_resp.size() != 0 || draw_valid !== 1'b0)
      begin errors++; $display("FAIL %s_drain: got draw %0d resp %0d pending, draw_valid %b want 0,0,0", name, q_draw.size(), q_resp.size(), draw_valid); end
  endtask

  task automatic test_reset();
    idle(); draw_ready = 1'b0; memx = '0; memy = '0; wr_x = '0; wr_y = '0; game_health = '0;
    reset = 1'b1;
    step(); step();
    checks++;
    if ({ready, resp_valid, brickx, bricky, health, draw_valid, draw_x, draw_y, draw_health,
         bricks_left, all_cleared, overflow} !== '0)
      begin errors++; $display("FAIL reset_values: got ready=%b bl=%0d dv=%b ovf=%b want all zero", ready, bricks_left, draw_valid, overflow); end
    reset = 1'b0;
    model_init();
    wait_ready("reset");
    checks++;
    if (all_cleared !== 1'b0) begin errors++; $display("FAIL reset_all_cleared: got %b want 0", all_cleared); end
  endtask

  task automatic test_query();
    drive_query(45, 23); step();
    drive_query(100, 90); step();
    drive_query(319, 79); step();
    drive_query(320, 0); step();
    idle(); step();
    checks++;
    if ({brickx, bricky, health} !== 22'd0) begin errors++; $display("FAIL query_hold: got %0d,%0d,%0d want 0,0,0", brickx, bricky, health); end
    drain("query");
  endtask

  task automatic test_write();
    draw_ready = 1'b0;
    drive_write(41, 21, 2'd2); step(); idle();
    checks++;
    if ({draw_valid, draw_x, draw_y, draw_health} !== {1'b1, 10'd40, 10'd20, 2'd2})
      begin errors++; $display("FAIL write_head: got %b,%0d,%0d,%0d want 1,40,20,2", draw_valid, draw_x, draw_y, draw_health); end
    checks++;
    if (bricks_left !== 8'd128) begin errors++; $display("FAIL write_left: got %0d want 128", bricks_left); end
    draw_ready = 1'b1;
    drive_write(41, 21, 2'd0); step();
    drive_write(41, 21, 2'd0); step(); idle();
    drain("write");
    checks++;
    if (bricks_left !== 8'd127) begin errors++; $display("FAIL kill_left: got %0d want 127", bricks_left); end
  endtask

  task automatic test_overflow();
    draw_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin drive_write(c * 20 + 5, 35, 2'd1); step(); end
    idle();
    checks++;
    if ({overflow, draw_valid, draw_x, draw_y, draw_health} !== {1'b1, 1'b1, 10'd0, 10'd30, 2'd1})
      begin errors++; $display("FAIL ovf_state: got ovf=%b dv=%b %0d,%0d,%0d want 1,1,0,30,1", overflow, draw_valid, draw_x, draw_y, draw_health); end
    checks++;
    if (exp_h[52] !== 2'd1 || bricks_left !== 8'(exp_left))
      begin errors++; $display("FAIL ovf_left: got %0d want %0d", bricks_left, exp_left); end
    draw_ready = 1'b1;
    drain("ovf");
    drive_query(85, 35); step(); idle(); drain("ovf_commit");
  endtask

  task automatic test_back_to_back();
    draw_ready = 1'b1;
    drive_query(45, 23); drive_write(45, 23, 2'd3); step(); idle();
    drive_query(45, 23); step(); idle();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(1, 0) == 1) drive_query($urandom_range(399, 0), $urandom_range(119, 0));
      else query_valid = 1'b0;
      if ($urandom_range(1, 0) == 1) drive_write($urandom_range(399, 0), $urandom_range(119, 0), 2'($urandom_range(3, 0)));
      else game_write = 1'b0;
      step();
    end
    idle();
    drain("b2b");
    checks++;
    if (bricks_left !== 8'(exp_left)) begin errors++; $display("FAIL b2b_left: got %0d want %0d", bricks_left, exp_left); end
  endtask

  task automatic test_clear_all();
    draw_ready = 1'b1;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++) begin drive_write(c * 20 + 19, r * 10 + 9, 2'd0); step(); end
    idle();
    drain("clear");
    checks++;
    if ({bricks_left, all_cleared} !== {8'd0, 1'b1})
      begin errors++; $display("FAIL clear_state: got left=%0d cleared=%b want 0,1", bricks_left, all_cleared); end
    drive_write(5, 5, 2'd3); step(); idle(); step();
    checks++;
    if ({draw_valid, bricks_left} !== {1'b0, 8'd0})
      begin errors++; $display("FAIL dead_write: got dv=%b left=%0d want 0,0", draw_valid, bricks_left); end
    drive_query(319, 79); step(); idle();
    drain("clear_query");
  endtask

  task automatic test_reset_mid_init();
    reset = 1'b1; step(); reset = 1'b0;
    repeat (60) step();
    reset = 1'b1; step(); reset = 1'b0;
    model_init();
    checks++;
    if ({ready, overflow, bricks_left} !== '0)
      begin errors++; $display("FAIL mid_reset_values: got ready=%b ovf=%b left=%0d want 0,0,0", ready, overflow, bricks_left); end
    wait_ready("mid_init");
    drive_query(45, 23); step();
    drive_query(319, 79); step(); idle();
    drain("mid_init");
  endtask

  initial begin
    test_reset();
    test_query();
    test_write();
    test_overflow();
    test_back_to_back();
    test_clear_all();
    test_reset_mid_init();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
